// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory bridge: FSM state encoding,
// bus transfer sizes and the kseg0/kseg1 unmapped-segment translation constants.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_t;

    // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) share top bits 2'b10 and both
    // alias the low 512 MB of physical memory.
    localparam logic [1:0]  KSEG01_TAG     = 2'b10;
    localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/addr_xlate.sv
// Combinational virtual-to-physical mapping for the unmapped kernel segments;
// every other address passes through untouched.
module addr_xlate
    import cpu_mem_pkg::*;
#(
    parameter bit KSEG_MAP = 1'b1
)(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    always_comb begin
        paddr = vaddr;
        if (KSEG_MAP && (vaddr[31:30] == KSEG01_TAG)) begin
            paddr = vaddr & KSEG_PHYS_MASK;
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Serialises instruction-fetch and data-access requests onto a single SRAM-like
// bus with one transaction outstanding, and raises pipeline stalls until each completes.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter bit KSEG_MAP   = 1'b1,
    parameter bit DATA_FIRST = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        stallreq_from_if,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [3:0]  sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,
    input  logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    state_t      state, state_next;
    logic        i_done, d_done;
    logic        i_pend, d_pend;
    logic        issue_i, issue_d;
    logic        i_complete, d_complete;
    logic [31:0] if_paddr, mem_paddr;

    addr_xlate #(.KSEG_MAP(KSEG_MAP)) u_xlate_if  (.vaddr(if_pc),    .paddr(if_paddr));
    addr_xlate #(.KSEG_MAP(KSEG_MAP)) u_xlate_mem (.vaddr(mem_addr), .paddr(mem_paddr));

    assign d_pend            = mem_en  & ~d_done;
    assign i_pend            = inst_en & ~i_done;
    assign stallreq_from_mem = d_pend;
    assign stallreq_from_if  = i_pend;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with <= so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        bus_req    = 1'b0;
        issue_i    = 1'b0;
        issue_d    = 1'b0;
        i_complete = 1'b0;
        d_complete = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_pend && (DATA_FIRST || !i_pend)) begin
                    issue_d    = 1'b1;
                    state_next = D_ADDR;
                end else if (i_pend) begin
                    issue_i    = 1'b1;
                    state_next = I_ADDR;
                end
            end
            I_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    i_complete = bus_data_ok;
                    state_next = bus_data_ok ? IDLE : I_DATA;
                end
            end
            I_DATA: begin
                if (bus_data_ok) begin
                    i_complete = 1'b1;
                    state_next = IDLE;
                end
            end
            D_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    d_complete = bus_data_ok;
                    state_next = bus_data_ok ? IDLE : D_DATA;
                end
            end
            D_DATA: begin
                if (bus_data_ok) begin
                    d_complete = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched on the issue edge and stay frozen until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_wr    <= 1'b0;
            bus_size  <= 2'b00;
            bus_wstrb <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else if (issue_d) begin
            bus_wr    <= mem_we;
            bus_size  <= mem_size;
            bus_wstrb <= mem_we ? sel : 4'b0000;
            bus_addr  <= mem_paddr;
            bus_wdata <= mem_wdata;
        end else if (issue_i) begin
            bus_wr    <= 1'b0;
            bus_size  <= SIZE_W;
            bus_wstrb <= 4'b0000;
            bus_addr  <= if_paddr;
            bus_wdata <= 32'h0;
        end
    end

    // A completion only counts if its request is still asserted; a flushed one is dropped.
    // Done flags survive only while the pipeline is stalled, so the advance edge clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_done    <= 1'b0;
            i_done    <= 1'b0;
            mem_rdata <= 32'h0;
            if_instr  <= 32'h0;
        end else begin
            d_done <= cpu_stall & (d_done | (d_complete & mem_en));
            i_done <= cpu_stall & (i_done | (i_complete & inst_en));
            if (d_complete && mem_en && !bus_wr) mem_rdata <= bus_rdata;
            if (i_complete && inst_en)           if_instr  <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: a randomised-latency bus slave logs every
// accepted request, and a transaction-level model predicts bus fields and results.
module tb_cpu_mem_bridge;

    localparam bit DATA_FIRST_P = 1'b1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en, mem_en, mem_we, cpu_stall, ext_stall;
    logic [31:0] if_pc, if_instr, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  sel;
    logic [1:0]  mem_size;
    logic        stallreq_from_if, stallreq_from_mem;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int checks   = 0;
    int failures = 0;

    txn_t        log_q[$];
    logic [31:0] rdata_q[$];
    logic [31:0] m_rdata, m_instr;
    int          force_alat, force_dlat;
    bit          spurious;

    always #5 clk = ~clk;

    assign cpu_stall = stallreq_from_if | stallreq_from_mem | ext_stall;

    cpu_mem_bridge #(.KSEG_MAP(1'b1), .DATA_FIRST(DATA_FIRST_P)) dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .if_pc(if_pc), .if_instr(if_instr), .stallreq_from_if(stallreq_from_if),
        .mem_en(mem_en), .mem_we(mem_we), .sel(sel), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq_from_mem(stallreq_from_mem),
        .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // kseg0 and kseg1 each alias the bottom 512 MB; everything else is identity.
    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        return va;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = $urandom % 32'h2000_0000;
        case ($urandom_range(0, 3))
            0:       return off;
            1:       return 32'h8000_0000 + off;
            2:       return 32'hA000_0000 + off;
            default: return 32'hC000_0000 + off;
        endcase
    endfunction

    // Bus slave: random or forced accept/response latency, logs accepted requests.
    initial begin : slave
        int   phase, cnt, dl;
        txn_t snap;
        phase = 0; cnt = 0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rst) begin
                phase = 0;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = $urandom;
                    rdata_q.push_back(bus_rdata);
                    phase = 0;
                end else cnt--;
            end else if (bus_req) begin
                if (phase == 1) begin
                    check("hold_addr", bus_addr, snap.addr);
                    check("hold_ctl", 32'({bus_wr, bus_size, bus_wstrb}),
                          32'({snap.wr, snap.size, snap.wstrb}));
                    check("hold_wdata", bus_wdata, snap.wdata);
                end else begin
                    snap = '{addr: bus_addr, wr: bus_wr, size: bus_size, wstrb: bus_wstrb, wdata: bus_wdata};
                    phase = 1;
                    cnt = (force_alat >= 0) ? force_alat : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    bus_addr_ok = 1'b1;
                    log_q.push_back(snap);
                    dl = (force_dlat >= 0) ? force_dlat : int'($urandom_range(0, 3));
                    if (dl == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = $urandom;
                        rdata_q.push_back(bus_rdata);
                        phase = 0;
                    end else begin
                        phase = 2;
                        cnt = dl - 1;
                    end
                end else begin
                    cnt--;
                    if (spurious && $urandom_range(0, 2) == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = $urandom;
                    end
                end
            end else begin
                phase = 0;
                if (spurious && $urandom_range(0, 2) == 0) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = $urandom;
                end
            end
        end
    end

    // One pipeline step: present requests, wait for both stalls to drop, then check
    // the bus transactions and result registers against the model.
    task automatic access(input bit ie, input logic [31:0] pc, input bit me, input bit we,
                          input logic [1:0] sz, input logic [3:0] s, input logic [31:0] ma,
                          input logic [31:0] wd, input int exp_lat, input bit keep);
        txn_t exp_q[$];
        bit   kind_q[$];  // 1 = data, 0 = fetch
        int   n0, t, t_if, t_mem, idx;
        txn_t d_txn, i_txn;
        n0 = log_q.size();
        tick();
        inst_en = ie; if_pc = pc; mem_en = me; mem_we = we; mem_size = sz;
        sel = s; mem_addr = ma; mem_wdata = wd;
        #1;
        t = 0; t_if = -1; t_mem = -1;
        while ((stallreq_from_if || stallreq_from_mem) && t < 200) begin
            tick();
            t++;
            if (t_if  < 0 && !stallreq_from_if)  t_if  = t;
            if (t_mem < 0 && !stallreq_from_mem) t_mem = t;
        end
        check("stall_timeout", 32'(t < 200), 32'd1);

        d_txn = '{addr: phys(ma), wr: we, size: sz, wstrb: we ? s : 4'b0000, wdata: wd};
        i_txn = '{addr: phys(pc), wr: 1'b0, size: 2'd2, wstrb: 4'b0000, wdata: 32'h0};
        if (me && (DATA_FIRST_P || !ie)) begin exp_q.push_back(d_txn); kind_q.push_back(1'b1); end
        if (ie)                          begin exp_q.push_back(i_txn); kind_q.push_back(1'b0); end
        if (me && !DATA_FIRST_P && ie)   begin exp_q.push_back(d_txn); kind_q.push_back(1'b1); end

        check("txn_count", 32'(log_q.size() - n0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            idx = n0 + k;
            if (idx < log_q.size() && idx < rdata_q.size()) begin
                check("bus_addr", log_q[idx].addr, exp_q[k].addr);
                check("bus_ctl", 32'({log_q[idx].wr, log_q[idx].size, log_q[idx].wstrb}),
                      32'({exp_q[k].wr, exp_q[k].size, exp_q[k].wstrb}));
                if (exp_q[k].wr) check("bus_wdata", log_q[idx].wdata, exp_q[k].wdata);
                if (kind_q[k] && !we) m_rdata = rdata_q[idx];
                if (!kind_q[k])       m_instr = rdata_q[idx];
            end
        end
        check("mem_rdata", mem_rdata, m_rdata);
        check("if_instr", if_instr, m_instr);
        if (exp_lat > 0) check("latency", 32'(t), 32'(exp_lat));
        if (ie && me) check("stall_order", 32'(t_mem < t_if), 32'd1);
        if (!keep) begin
            inst_en = 1'b0;
            mem_en  = 1'b0;
        end
    endtask

    initial begin : main
        int n0, r0, w;
        bit ie, me, we;
        int kind;
        rst = 1'b1; ext_stall = 1'b0; spurious = 1'b0;
        inst_en = 1'b0; if_pc = 32'h0; mem_en = 1'b0; mem_we = 1'b0; sel = 4'h0;
        mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
        force_alat = 0; force_dlat = 0;
        m_rdata = 32'h0; m_instr = 32'h0;

        repeat (2) tick();
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_ctl", 32'({bus_wr, bus_size, bus_wstrb}), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_results", if_instr | mem_rdata, 32'h0);
        rst = 1'b0;

        // Boot fetch through kseg1 on a zero-wait bus.
        access(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 2, 1'b0);
        check("boot_paddr", log_q[log_q.size() - 1].addr, 32'h1FC0_0000);

        // Fetch and load together: data goes first, then the fetch.
        access(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 2'd2, 4'hF, 32'h8000_1004, 32'h0, 4, 1'b0);
        check("both_first_paddr", log_q[log_q.size() - 2].addr, 32'h0000_1004);

        // Single zero-wait load.
        access(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0040_0010, 32'h0, 2, 1'b0);

        // Byte store held across three cycles without addr_ok.
        force_alat = 3; force_dlat = 1;
        access(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 4'b0100, 32'h8000_2002, 32'h00AB_0000, 0, 1'b0);
        check("store_wstrb", 32'(log_q[log_q.size() - 1].wstrb), 32'b0100);

        // Load completes while the pipeline is held: no re-issue, result retained.
        force_alat = -1; force_dlat = -1;
        tick();
        ext_stall = 1'b1;
        access(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 4'hF, 32'hA000_0010, 32'h0, 0, 1'b1);
        n0 = log_q.size();
        repeat (4) begin
            tick();
            check("held_stall_mem", 32'(stallreq_from_mem), 32'd0);
            check("held_rdata", mem_rdata, m_rdata);
        end
        check("held_no_reissue", 32'(log_q.size()), 32'(n0));
        ext_stall = 1'b0;
        tick();
        check("done_cleared", 32'(stallreq_from_mem), 32'd1);
        mem_en = 1'b0;
        tick();
        check("cleared_no_reissue", 32'(log_q.size()), 32'(n0));

        // Fetch withdrawn while its response is outstanding.
        ext_stall = 1'b1; force_alat = 0; force_dlat = 3;
        n0 = log_q.size(); r0 = rdata_q.size();
        inst_en = 1'b1; if_pc = 32'h8000_0400;
        w = 0;
        while (log_q.size() == n0 && w < 50) begin tick(); w++; end
        check("flush_accept", 32'(log_q.size()), 32'(n0 + 1));
        tick();
        inst_en = 1'b0;
        w = 0;
        while (rdata_q.size() == r0 && w < 50) begin tick(); w++; end
        check("flush_resp", 32'(rdata_q.size()), 32'(r0 + 1));
        tick();
        check("flush_instr", if_instr, m_instr);
        inst_en = 1'b1;
        #1;
        check("flush_no_done", 32'(stallreq_from_if), 32'd1);
        ext_stall = 1'b0; force_alat = -1; force_dlat = -1;
        access(1'b1, 32'h8000_0400, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1'b0);

        // Reset while the data request waits for addr_ok.
        tick();
        force_alat = 6; force_dlat = 0;
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; sel = 4'hF; mem_addr = 32'h8000_0800;
        tick();
        tick();
        check("pre_rst_req", 32'(bus_req), 32'd1);
        n0 = log_q.size();
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus_req), 32'd0);
        check("mid_rst_ctl", 32'({bus_wr, bus_size, bus_wstrb}), 32'd0);
        check("mid_rst_addr", bus_addr, 32'h0);
        check("mid_rst_wdata", bus_wdata, 32'h0);
        check("mid_rst_results", if_instr | mem_rdata, 32'h0);
        check("mid_rst_stall", 32'(stallreq_from_mem), 32'd1);
        m_rdata = 32'h0; m_instr = 32'h0;
        tick();
        rst = 1'b0; mem_en = 1'b0;
        force_alat = -1; force_dlat = -1;
        access(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h8000_0800, 32'h0, 0, 1'b0);
        check("post_rst_txns", 32'(log_q.size()), 32'(n0 + 1));

        // Random traffic with random bus latency and stray data_ok pulses.
        spurious = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            ie = (kind == 0) || (kind == 3);
            me = (kind != 0);
            we = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
            access(ie, rand_addr() & 32'hFFFF_FFFC, me, we, 2'($urandom_range(0, 2)),
                   4'($urandom_range(1, 15)), rand_addr(), $urandom, 0, 1'b0);
        end
        spurious = 1'b0;

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
